// File: rtl/elevator_scheduler.sv
// ============================================================================
// elevator_scheduler : single-car collective (SCAN) scheduler for floors 0..7
//                      with per-floor travel timing, door dwell and clear strobe
// Revision: 1.0
// ============================================================================
`default_nettype none

module elevator_scheduler #(
    parameter int unsigned FLOOR_TICKS = 4,
    parameter int unsigned DOOR_TICKS  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] call_inside,
    input  logic [7:0] call_up,
    input  logic [7:0] call_down,
    output logic [2:0] floor,
    output logic       dir_up,
    output logic       moving,
    output logic       door_open,
    output logic       clr_valid,
    output logic [2:0] clr_floor
);

    localparam logic [7:0] C_FLOOR_LAST = 8'(FLOOR_TICKS - 1);
    localparam logic [7:0] C_DOOR_LAST  = 8'(DOOR_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2,
        S_DOOR      = 2'd3
    } state_t;

    state_t     r_state;
    logic [2:0] r_floor;
    logic       r_dir_up;
    logic       r_moving;
    logic       r_door_open;
    logic       r_clr_valid;
    logic [2:0] r_clr_floor;
    logic [7:0] r_timer;
    logic       r_eval;
    logic [1:0] r_since;

    logic [7:0] w_pending;
    logic       w_above;
    logic       w_below;
    logic       w_here;
    logic       w_ahead;
    logic       w_hall;
    logic       w_stop;

    // Shifting by floor+1 / 8-floor drops the current floor; the extra bit makes floor 7 / floor 0 yield zero.
    assign w_pending = call_inside | call_up | call_down;
    assign w_above   = |(w_pending >> ({1'b0, r_floor} + 4'd1));
    assign w_below   = |(w_pending << (4'd8 - {1'b0, r_floor}));
    assign w_here    = w_pending[r_floor];
    assign w_ahead   = (r_state == S_MOVE_DOWN) ? w_below : w_above;
    assign w_hall    = (r_state == S_MOVE_DOWN) ? call_down[r_floor] : call_up[r_floor];
    assign w_stop    = call_inside[r_floor] | w_hall | (w_here & ~w_ahead);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_floor     <= 3'd0;
            r_dir_up    <= 1'b1;
            r_moving    <= 1'b0;
            r_door_open <= 1'b0;
            r_clr_valid <= 1'b0;
            r_clr_floor <= 3'd0;
            r_timer     <= 8'd0;
            r_eval      <= 1'b0;
            r_since     <= 2'd3;
        end else begin
            r_clr_valid <= 1'b0;
            if (r_since != 2'd3) begin
                r_since <= r_since + 2'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_here) begin
                        r_state     <= S_DOOR;
                        r_door_open <= 1'b1;
                        r_clr_valid <= 1'b1;
                        r_clr_floor <= r_floor;
                        r_since     <= 2'd0;
                        r_timer     <= 8'd0;
                    end else if (w_above && (r_dir_up || !w_below)) begin
                        r_state  <= S_MOVE_UP;
                        r_dir_up <= 1'b1;
                        r_moving <= 1'b1;
                        r_timer  <= 8'd0;
                        r_eval   <= 1'b0;
                    end else if (w_below) begin
                        r_state  <= S_MOVE_DOWN;
                        r_dir_up <= 1'b0;
                        r_moving <= 1'b1;
                        r_timer  <= 8'd0;
                        r_eval   <= 1'b0;
                    end
                end
                S_MOVE_UP, S_MOVE_DOWN: begin
                    if (r_eval) begin
                        r_eval  <= 1'b0;
                        r_timer <= 8'd0;
                        if (w_stop) begin
                            r_state     <= S_DOOR;
                            r_moving    <= 1'b0;
                            r_door_open <= 1'b1;
                            r_clr_valid <= 1'b1;
                            r_clr_floor <= r_floor;
                            r_since     <= 2'd0;
                        end else if (!w_ahead) begin
                            r_state  <= S_IDLE;
                            r_moving <= 1'b0;
                        end
                    end else if (r_timer == C_FLOOR_LAST) begin
                        r_timer <= 8'd0;
                        r_eval  <= 1'b1;
                        r_floor <= (r_state == S_MOVE_UP) ? r_floor + 3'd1 : r_floor - 3'd1;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_DOOR: begin
                    // A request still present two cycles after the strobe is a fresh press at the open door.
                    if (w_here && r_since >= 2'd2) begin
                        r_clr_valid <= 1'b1;
                        r_clr_floor <= r_floor;
                        r_since     <= 2'd0;
                        r_timer     <= 8'd0;
                    end else if (r_timer == C_DOOR_LAST) begin
                        r_state     <= S_IDLE;
                        r_door_open <= 1'b0;
                        r_timer     <= 8'd0;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign floor     = r_floor;
    assign dir_up    = r_dir_up;
    assign moving    = r_moving;
    assign door_open = r_door_open;
    assign clr_valid = r_clr_valid;
    assign clr_floor = r_clr_floor;

endmodule

`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
// ============================================================================
// tb_elevator_scheduler : directed and randomized checks of elevator_scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_elevator_scheduler;

    localparam int FT = 4;
    localparam int DT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] call_inside = 8'h00;
    logic [7:0] call_up = 8'h00;
    logic [7:0] call_down = 8'h00;
    logic [2:0] floor;
    logic       dir_up;
    logic       moving;
    logic       door_open;
    logic       clr_valid;
    logic [2:0] clr_floor;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int t;
        int f;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  m_floor = 0;
    bit  m_dir = 1'b1;
    int  n_moving;
    int  n_door;
    int  proto_err;
    int  t_quiet;
    bit  quiet;

    elevator_scheduler #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
        .clk         (clk),
        .reset       (reset),
        .call_inside (call_inside),
        .call_up     (call_up),
        .call_down   (call_down),
        .floor       (floor),
        .dir_up      (dir_up),
        .moving      (moving),
        .door_open   (door_open),
        .clr_valid   (clr_valid),
        .clr_floor   (clr_floor)
    );

    always #5 clk = ~clk;

    function automatic bit any_above(input logic [7:0] p, input int f);
        bit r = 1'b0;
        for (int g = f + 1; g < 8; g++) if (p[g]) r = 1'b1;
        return r;
    endfunction

    function automatic bit any_below(input logic [7:0] p, input int f);
        bit r = 1'b0;
        for (int g = 0; g < f; g++) if (p[g]) r = 1'b1;
        return r;
    endfunction

    // Upstream retire rule: car call plus the hall call matching the direction (else the other one).
    task automatic retire(inout logic [7:0] ci, inout logic [7:0] cu, inout logic [7:0] cd,
                          input int f, input bit up);
        ci[f] = 1'b0;
        if (up) begin
            if (cu[f]) cu[f] = 1'b0; else cd[f] = 1'b0;
        end else begin
            if (cd[f]) cd[f] = 1'b0; else cu[f] = 1'b0;
        end
    endtask

    // Event-level SCAN model: times are cycles after the IDLE cycle in which requests appear.
    task automatic model_run(input logic [7:0] ci0, input logic [7:0] cu0, input logic [7:0] cd0,
                             output int t_end);
        logic [7:0] ci = ci0;
        logic [7:0] cu = cu0;
        logic [7:0] cd = cd0;
        logic [7:0] p;
        int t = 0;
        int f = m_floor;
        int e;
        int c;
        bit dir = m_dir;
        bit done = 1'b0;
        bit ahead;
        ev_t ev;
        exp_q.delete();
        for (int it = 0; it < 64 && !done; it++) begin
            p = ci | cu | cd;
            c = -1;
            if (p[f]) begin
                c = t + 1;
            end else if (any_above(p, f) || any_below(p, f)) begin
                dir = any_above(p, f) && (dir || !any_below(p, f));
                e = t + 1 + FT;
                f = dir ? f + 1 : f - 1;
                for (int s = 0; s < 8; s++) begin
                    p = ci | cu | cd;
                    ahead = dir ? any_above(p, f) : any_below(p, f);
                    if (ci[f] || (dir ? cu[f] : cd[f]) || (p[f] && !ahead)) begin
                        c = e + 1;
                        break;
                    end
                    if (!ahead) begin
                        t = e + 1;
                        break;
                    end
                    e = e + FT + 1;
                    f = dir ? f + 1 : f - 1;
                end
            end else begin
                done = 1'b1;
            end
            if (c >= 0) begin
                ev.t = c; ev.f = f;
                exp_q.push_back(ev);
                retire(ci, cu, cd, f, dir);
                p = ci | cu | cd;
                while (p[f]) begin
                    c = c + ((DT >= 3) ? 3 : DT + 1);
                    ev.t = c; ev.f = f;
                    exp_q.push_back(ev);
                    retire(ci, cu, cd, f, dir);
                    p = ci | cu | cd;
                end
                t = c + DT;
            end
        end
        m_floor = f;
        m_dir   = dir;
        t_end   = t;
    endtask

    // Drives requests from an IDLE negedge, retires them on each strobe, stops at quiescence.
    task automatic run_calls(input logic [7:0] ci, input logic [7:0] cu, input logic [7:0] cd,
                             input int budget);
        int  last_floor = int'(floor);
        bit  prev_clr = 1'b0;
        ev_t ev;
        obs_q.delete();
        n_moving = 0; n_door = 0; proto_err = 0; quiet = 1'b0; t_quiet = -1;
        call_inside = ci; call_up = cu; call_down = cd;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (moving) n_moving++;
            if (door_open) n_door++;
            if (int'(floor) - last_floor > 1 || last_floor - int'(floor) > 1) proto_err++;
            last_floor = int'(floor);
            if (clr_valid) begin
                if (prev_clr || !door_open || clr_floor != floor) proto_err++;
                ev.t = k; ev.f = int'(clr_floor);
                obs_q.push_back(ev);
                retire(call_inside, call_up, call_down, int'(clr_floor), dir_up);
            end
            prev_clr = clr_valid;
            if (!clr_valid && !moving && !door_open && (call_inside | call_up | call_down) == 8'h00) begin
                quiet = 1'b1;
                t_quiet = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int n_clr = 0, n_mv = 0, n_dr = 0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (floor !== 3'd0) begin errors++; $display("FAIL reset_floor: got %0d expected 0", floor); end
        checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL reset_dir_up: got %0b expected 1", dir_up); end
        checks++; if (moving !== 1'b0) begin errors++; $display("FAIL reset_moving: got %0b expected 0", moving); end
        checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL reset_door: got %0b expected 0", door_open); end
        checks++; if (clr_valid !== 1'b0) begin errors++; $display("FAIL reset_clr_valid: got %0b expected 0", clr_valid); end
        checks++; if (clr_floor !== 3'd0) begin errors++; $display("FAIL reset_clr_floor: got %0d expected 0", clr_floor); end
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (clr_valid) n_clr++;
            if (moving) n_mv++;
            if (door_open) n_dr++;
        end
        checks++; if (n_clr != 0) begin errors++; $display("FAIL idle_clr: got %0d pulses expected 0", n_clr); end
        checks++; if (n_mv != 0) begin errors++; $display("FAIL idle_moving: got %0d cycles expected 0", n_mv); end
        checks++; if (n_dr != 0) begin errors++; $display("FAIL idle_door: got %0d cycles expected 0", n_dr); end
        checks++; if (floor !== 3'd0) begin errors++; $display("FAIL idle_floor: got %0d expected 0", floor); end
    endtask

    task automatic test_single_call;
        int t_end;
        model_run(8'h08, 8'h00, 8'h00, t_end);
        run_calls(8'h08, 8'h00, 8'h00, 300);
        checks++; if (!quiet) begin errors++; $display("FAIL single_timeout: got no idle expected idle"); end
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", obs_q.size()); end
        else begin
            checks++; if (obs_q[0].f != 3 || obs_q[0].t != 16) begin
                errors++; $display("FAIL single_clr: got floor %0d at %0d expected floor 3 at 16", obs_q[0].f, obs_q[0].t);
            end
        end
        checks++; if (n_moving != 15) begin errors++; $display("FAIL single_moving: got %0d expected 15", n_moving); end
        checks++; if (n_door != DT) begin errors++; $display("FAIL single_door: got %0d expected %0d", n_door, DT); end
        checks++; if (floor !== 3'd3 || dir_up !== 1'b1) begin
            errors++; $display("FAIL single_end: got floor %0d dir %0b expected floor 3 dir 1", floor, dir_up);
        end
        checks++; if (proto_err != 0) begin errors++; $display("FAIL single_protocol: got %0d violations expected 0", proto_err); end
    endtask

    task automatic test_pass_by;
        int t_end;
        model_run(8'h01, 8'h00, 8'h00, t_end);
        run_calls(8'h01, 8'h00, 8'h00, 300);
        checks++; if (floor !== 3'd0 || !quiet) begin errors++; $display("FAIL home_floor: got %0d expected 0", floor); end
        model_run(8'h00, 8'h20, 8'h04, t_end);
        run_calls(8'h00, 8'h20, 8'h04, 400);
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL passby_pulses: got %0d expected 2", obs_q.size()); end
        else begin
            checks++; if (obs_q[0].f != 5 || obs_q[0].t != 26) begin
                errors++; $display("FAIL passby_first: got floor %0d at %0d expected floor 5 at 26", obs_q[0].f, obs_q[0].t);
            end
            checks++; if (obs_q[1].f != 2 || obs_q[1].t != 45) begin
                errors++; $display("FAIL passby_second: got floor %0d at %0d expected floor 2 at 45", obs_q[1].f, obs_q[1].t);
            end
        end
        checks++; if (dir_up !== 1'b0 || floor !== 3'd2) begin
            errors++; $display("FAIL passby_end: got floor %0d dir %0b expected floor 2 dir 0", floor, dir_up);
        end
        checks++; if (t_quiet != 48) begin errors++; $display("FAIL passby_idle_time: got %0d expected 48", t_quiet); end
    endtask

    task automatic test_end_floors;
        int t_end;
        model_run(8'h00, 8'h00, 8'h80, t_end);
        run_calls(8'h00, 8'h00, 8'h80, 400);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL top_pulses: got %0d expected 1", obs_q.size()); end
        else begin
            checks++; if (obs_q[0].f != 7 || obs_q[0].t != 26) begin
                errors++; $display("FAIL top_clr: got floor %0d at %0d expected floor 7 at 26", obs_q[0].f, obs_q[0].t);
            end
        end
        checks++; if (floor !== 3'd7 || !quiet || proto_err != 0) begin
            errors++; $display("FAIL top_end: got floor %0d violations %0d expected floor 7 violations 0", floor, proto_err);
        end
        model_run(8'h00, 8'h01, 8'h00, t_end);
        run_calls(8'h00, 8'h01, 8'h00, 400);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL bottom_pulses: got %0d expected 1", obs_q.size()); end
        else begin
            checks++; if (obs_q[0].f != 0 || obs_q[0].t != 36) begin
                errors++; $display("FAIL bottom_clr: got floor %0d at %0d expected floor 0 at 36", obs_q[0].f, obs_q[0].t);
            end
        end
        checks++; if (floor !== 3'd0 || dir_up !== 1'b0 || proto_err != 0) begin
            errors++; $display("FAIL bottom_end: got floor %0d dir %0b violations %0d expected 0 0 0", floor, dir_up, proto_err);
        end
    endtask

    task automatic test_door_repress;
        int t_end;
        int c_first = -1, c_second = -1, door_after = 0, pulses = 0;
        model_run(8'h10, 8'h00, 8'h00, t_end);
        call_inside = 8'h10;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (c_first >= 0 && k == c_first + 2) call_inside[4] = 1'b1;
            if (clr_valid) begin
                pulses++;
                if (c_first < 0) c_first = k; else c_second = k;
                retire(call_inside, call_up, call_down, int'(clr_floor), dir_up);
            end
            if (c_second >= 0 && door_open) door_after++;
            if (c_second >= 0 && !door_open) break;
        end
        checks++; if (pulses != 2) begin errors++; $display("FAIL repress_pulses: got %0d expected 2", pulses); end
        checks++; if (c_second - c_first != 3) begin
            errors++; $display("FAIL repress_gap: got %0d expected 3", c_second - c_first);
        end
        checks++; if (door_after != DT) begin errors++; $display("FAIL repress_door: got %0d expected %0d", door_after, DT); end
        checks++; if (floor !== 3'd4 || clr_floor !== 3'd4) begin
            errors++; $display("FAIL repress_floor: got %0d/%0d expected 4/4", floor, clr_floor);
        end
    endtask

    task automatic test_reset_mid_travel;
        int t_end, n_clr = 0;
        bit seen = 1'b0;
        model_run(8'h01, 8'h00, 8'h00, t_end);
        run_calls(8'h01, 8'h00, 8'h00, 300);
        call_inside = 8'h80;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (floor == 3'd3 && moving) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL midreset_reach: got no travel past 3 expected travel"); end
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (floor !== 3'd0 || moving !== 1'b0 || door_open !== 1'b0) begin
            errors++; $display("FAIL midreset_async: got floor %0d moving %0b door %0b expected 0 0 0", floor, moving, door_open);
        end
        checks++; if (dir_up !== 1'b1 || clr_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_flags: got dir %0b clr %0b expected 1 0", dir_up, clr_valid);
        end
        call_inside = 8'h00;
        repeat (2) begin
            @(negedge clk);
            if (clr_valid) n_clr++;
        end
        reset = 1'b1;
        m_floor = 0;
        m_dir = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (clr_valid) n_clr++;
        end
        checks++; if (n_clr != 0) begin errors++; $display("FAIL midreset_clr: got %0d pulses expected 0", n_clr); end
        checks++; if (floor !== 3'd0 || moving !== 1'b0) begin
            errors++; $display("FAIL midreset_after: got floor %0d moving %0b expected 0 0", floor, moving);
        end
    endtask

    task automatic test_random;
        logic [7:0] ci, cu, cd;
        int t_end;
        for (int n = 0; n < 40; n++) begin
            ci = 8'($urandom) & 8'($urandom) & 8'($urandom);
            cu = 8'($urandom) & 8'($urandom) & 8'($urandom);
            cd = 8'($urandom) & 8'($urandom) & 8'($urandom);
            if ((ci | cu | cd) == 8'h00) ci[$urandom_range(0, 7)] = 1'b1;
            model_run(ci, cu, cd, t_end);
            run_calls(ci, cu, cd, t_end + 60);
            checks++; if (!quiet) begin errors++; $display("FAIL rand%0d_timeout: got no idle expected idle by %0d", n, t_end); end
            checks++; if (obs_q.size() != exp_q.size()) begin
                errors++; $display("FAIL rand%0d_pulses: got %0d expected %0d", n, obs_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++; if (obs_q[i].t != exp_q[i].t || obs_q[i].f != exp_q[i].f) begin
                        errors++; $display("FAIL rand%0d_clr%0d: got floor %0d at %0d expected floor %0d at %0d",
                                           n, i, obs_q[i].f, obs_q[i].t, exp_q[i].f, exp_q[i].t);
                    end
                end
            end
            checks++; if (t_quiet != t_end) begin errors++; $display("FAIL rand%0d_idle_time: got %0d expected %0d", n, t_quiet, t_end); end
            checks++; if (int'(floor) != m_floor || dir_up !== m_dir) begin
                errors++; $display("FAIL rand%0d_end: got floor %0d dir %0b expected floor %0d dir %0b", n, floor, dir_up, m_floor, m_dir);
            end
            checks++; if (proto_err != 0) begin errors++; $display("FAIL rand%0d_protocol: got %0d violations expected 0", n, proto_err); end
        end
    endtask

    initial begin
        test_reset();
        test_single_call();
        test_pass_by();
        test_end_floors();
        test_door_repress();
        test_reset_mid_travel();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Single-car scheduler that consumes the decoded per-floor request vectors (call_inside, call_up, call_down) from the floor register file.
- Sequences car motion between floors 0..7 using the standard collective (SCAN) policy and times door dwell.
- Emits a one-cycle clear strobe naming the serviced floor, which upstream logic turns into a register write retiring that floor's request.

Parameters:
- FLOOR_TICKS, 4, clock cycles to travel one floor (legal range 1..255).
- DOOR_TICKS, 3, clock cycles the door stays open per service (legal range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- call_inside  input  8  car-button requests; bit n = floor n.
- call_up  input  8  hall up-call requests; bit n = floor n.
- call_down  input  8  hall down-call requests; bit n = floor n.
- floor  output  3  current car floor.
- dir_up  output  1  1 = travelling or preferring up; 0 = down.
- moving  output  1  high in MOVE_UP / MOVE_DOWN.
- door_open  output  1  high in DOOR.
- clr_valid  output  1  one-cycle strobe: request at clr_floor serviced.
- clr_floor  output  3  floor being cleared; valid only with clr_valid.

Behaviour:
- Reset (reset low, asynchronous): state IDLE, floor 0, dir_up 1, moving 0, door_open 0, clr_valid 0, clr_floor 0, both timers 0. Release is synchronous to the next clk edge.
- Derived signals:
  - pending = call_inside | call_up | call_down.
  - above = any pending bit > floor; below = any pending bit < floor.
  - at floor 7, above = 0; at floor 0, below = 0. The floor register never wraps.
- State IDLE (moving 0, door_open 0):
  - pending[floor] -> DOOR.
  - else above and (dir_up or !below) -> MOVE_UP, dir_up <= 1.
  - else below -> MOVE_DOWN, dir_up <= 0.
  - else stay in IDLE; dir_up holds.
- States MOVE_UP / MOVE_DOWN (moving 1):
  - Travel timer counts 0..FLOOR_TICKS-1.
  - On the cycle the count reaches FLOOR_TICKS-1: floor <= floor ±1 and the timer clears.
  - In the cycle after arrival, stop-evaluate at the new floor.
  - Stop condition: call_inside[floor], or the same-direction hall call (call_up when up, call_down when down), or pending[floor] with nothing further ahead.
  - Stop -> DOOR.
  - Ahead empty and pending[floor] = 0 -> IDLE.
  - Otherwise continue in the same state; the timer restarts.
  - Travel is 1 evaluation cycle plus FLOOR_TICKS cycles per floor.
  - A request appearing behind the car does not reverse it mid-travel.
- State DOOR (door_open 1, moving 0):
  - On entry: door_open rises and clr_valid = 1, clr_floor = floor, in the same cycle.
  - Door timer counts DOOR_TICKS cycles, then -> IDLE; door_open drops in the IDLE cycle.
  - If pending[floor] is re-asserted after the clear has been accepted (clr_valid low for at least 2 cycles): timer restarts and one more clr_valid pulse is issued. This covers a re-press at the open door.
  - dir_up is unchanged in DOOR. IDLE re-evaluates direction, preferring to continue the current direction.
- clr_valid:
  - Never high for two consecutive cycles.
  - Only asserted in DOOR.
  - Only for the current floor.
- Simultaneous events:
  - Up and down hall calls on the same floor: only the call matching the travel direction causes a stop while passing.
  - At the end of a sweep (nothing ahead), any pending call at that floor causes a stop.
  - A request for the current floor arriving while the car is in IDLE is served next cycle with no motion.
- Reset mid-travel or mid-door: immediate return to the reset state and floor 0. No clear strobe is emitted.

Test Plan:
- Reset with call_inside=8'h00, then release, run 20 cycles -> floor=0, IDLE, moving=0, door_open=0, clr_valid never 1.
- From floor 0 (FLOOR_TICKS=4, DOOR_TICKS=3), assert call_inside=8'h08 until the clr_valid with clr_floor=3 -> moving high about 15 cycles, floor steps 1,2,3, door_open high 3 cycles, then IDLE with dir_up=1.
- Car moving up from floor 0, call_down[2]=1 and call_up[5]=1 -> passes floor 2 without stopping, stops at 5 (clr_floor=5), reverses, stops at 2 (clr_floor=2), dir_up=0.
- Car at floor 7 with call_up[7]=0 and call_down[7]=1 arriving upward as the only request -> stops at 7, floor never exceeds 7; the same check at floor 0 going down.
- Door open at floor 4, re-press call_inside[4] 2 cycles after clr_valid -> second clr_valid pulse, door_open stays high for DOOR_TICKS cycles after the re-press.
- Assert reset low mid-travel between floors 3 and 4 -> outputs return to reset values asynchronously within the same cycle, floor=0, no clr_valid.
